// File: rtl/mux_8x1_pkg.sv
// mux_8x1_pkg: shared select width and select-code constants for the 8:1 selector
package mux_8x1_pkg;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_X1 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_X2 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_X3 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_X4 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_X5 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_X6 = 3'd5;
    localparam logic [SEL_W-1:0] SEL_X7 = 3'd6;
    localparam logic [SEL_W-1:0] SEL_X8 = 3'd7;
endpackage

// File: rtl/mux_8x1_if.sv
// mux_8x1_if: bundle of the selector's data, select and result signals
//   master drives x1..x8 and s1..s3 and observes y, y_q, sel_q (and y_par);
//   slave is the selector side. y_par exists only with MUX_8X1_PARITY_EN.
interface mux_8x1_if
    import mux_8x1_pkg::*;
#(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] x1, x2, x3, x4, x5, x6, x7, x8;
    logic             s1, s2, s3;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic [SEL_W-1:0] sel_q;
`ifdef MUX_8X1_PARITY_EN
    logic             y_par;
    modport master (output x1, x2, x3, x4, x5, x6, x7, x8, s1, s2, s3,
                    input y, y_q, sel_q, y_par);
    modport slave  (input x1, x2, x3, x4, x5, x6, x7, x8, s1, s2, s3,
                    output y, y_q, sel_q, y_par);
`else
    modport master (output x1, x2, x3, x4, x5, x6, x7, x8, s1, s2, s3,
                    input y, y_q, sel_q);
    modport slave  (input x1, x2, x3, x4, x5, x6, x7, x8, s1, s2, s3,
                    output y, y_q, sel_q);
`endif
endinterface

// File: rtl/mux_8x1_core.sv
// mux_8x1_core: purely combinational WIDTH-wide 8:1 case select
//   sel: 3-bit index, x1..x8: data inputs, y: selected data (X for unknown sel)
module mux_8x1_core
    import mux_8x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] x1, x2, x3, x4, x5, x6, x7, x8,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (sel)
            SEL_X1:  y = x1;
            SEL_X2:  y = x2;
            SEL_X3:  y = x3;
            SEL_X4:  y = x4;
            SEL_X5:  y = x5;
            SEL_X6:  y = x6;
            SEL_X7:  y = x7;
            SEL_X8:  y = x8;
            default: y = 'x;
        endcase
    end
endmodule

// File: rtl/mux_8x1.sv
// mux_8x1: 8:1 selector with combinational output and registered copy
//   x1..x8 data, s1 (MSB) s2 s3 (LSB) select, y combinational result,
//   clk/rst (sync, active-high), y_q/sel_q registered result and select.
//   Define MUX_8X1_PARITY_EN to add y_par, registered even parity of y.
module mux_8x1
    import mux_8x1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] x4,
    input  logic [WIDTH-1:0] x5,
    input  logic [WIDTH-1:0] x6,
    input  logic [WIDTH-1:0] x7,
    input  logic [WIDTH-1:0] x8,
    input  logic             s1,
    input  logic             s2,
    input  logic             s3,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic [SEL_W-1:0] sel_q
`ifdef MUX_8X1_PARITY_EN
    ,
    output logic             y_par
`endif
);
    logic [SEL_W-1:0] sel;
    assign sel = {s1, s2, s3};
    mux_8x1_core #(.WIDTH(WIDTH)) u_core (
        .sel(sel),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .x5(x5), .x6(x6), .x7(x7), .x8(x8),
        .y(y)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            sel_q <= '0;
        end else begin
            y_q   <= y;
            sel_q <= sel;
        end
    end
`ifdef MUX_8X1_PARITY_EN
    always_ff @(posedge clk) y_par <= rst ? 1'b0 : ^y;
`endif
endmodule

// File: tb/tb_mux_8x1.sv
// tb_mux_8x1: randomized scoreboard bench for mux_8x1 against an array-based model
module tb_mux_8x1;
    import mux_8x1_pkg::*;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] y;
        logic [2:0]   sel;
        logic         par;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;
    logic [W-1:0] d [8];
    logic [2:0] cur_s = 3'd0;
    exp_t q[$];
    exp_t m_e;
    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int n_pop = 0;
    always #5 if (clk_en) clk = ~clk;
    mux_8x1_if #(.WIDTH(W)) bus ();
    mux_8x1 #(.WIDTH(W)) dut (
        .x1(bus.x1), .x2(bus.x2), .x3(bus.x3), .x4(bus.x4),
        .x5(bus.x5), .x6(bus.x6), .x7(bus.x7), .x8(bus.x8),
        .s1(bus.s1), .s2(bus.s2), .s3(bus.s3),
        .y(bus.y),
        .clk(clk), .rst(rst),
        .y_q(bus.y_q), .sel_q(bus.sel_q)
`ifdef MUX_8X1_PARITY_EN
        , .y_par(bus.y_par)
`endif
    );
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask
    task automatic drive(input logic [2:0] s);
        cur_s = s;
        {bus.s1, bus.s2, bus.s3} = s;
        bus.x1 = d[0]; bus.x2 = d[1]; bus.x3 = d[2]; bus.x4 = d[3];
        bus.x5 = d[4]; bus.x6 = d[5]; bus.x7 = d[6]; bus.x8 = d[7];
        #1;
        check("y", bus.y, d[s]);
    endtask
    task automatic commit();
        exp_t e;
        e.y   = rst ? '0 : d[cur_s];
        e.sel = rst ? 3'd0 : cur_s;
        e.par = rst ? 1'b0 : 1'($countones(d[cur_s]) % 2);
        q.push_back(e);
        n_push++;
    endtask
    task automatic cycle(input logic [2:0] s, input logic r);
        @(negedge clk);
        rst = r;
        drive(s);
        commit();
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_pop++;
            check("y_q", bus.y_q, m_e.y);
            check("sel_q", {5'd0, bus.sel_q}, {5'd0, m_e.sel});
`ifdef MUX_8X1_PARITY_EN
            check("y_par", {7'd0, bus.y_par}, {7'd0, m_e.par});
`endif
        end
    end
    initial begin
        d = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0};
        for (int s = 0; s < 8; s++) begin
            drive(3'(s));
            #9;
        end
        clk_en = 1'b1;
        cycle(3'd0, 1'b1);
        cycle(3'd4, 1'b0);
        cycle(3'd3, 1'b0);
        cycle(3'd3, 1'b1);
        #2;
        check("y_in_rst", bus.y, 8'd1);
        cycle(3'd3, 1'b0);
        @(negedge clk);
        d[2] = 8'd0;
        drive(3'd2);
        d[2] = 8'd1;
        drive(3'd2);
        d[2] = 8'd0;
        drive(3'd2);
        d[2] = 8'd1;
        drive(3'd2);
        commit();
        @(negedge clk);
        d[2] = 8'd0;
        drive(3'd2);
        d[2] = 8'd1;
        drive(3'd2);
        d[2] = 8'd0;
        drive(3'd2);
        commit();
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        cycle(SEL_X8, 1'b0);
        cycle(SEL_X1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 8; k++) d[k] = W'($urandom);
            cycle(3'($urandom_range(0, 7)), $urandom_range(0, 31) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0 || n_pop != n_push) begin
            n_err++;
            $display("FAIL drain: popped %0d of %0d pushed", n_pop, n_push);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_8x1.md
Name: mux_8x1

Overview:
- 8-to-1 selector with combinational output and a registered copy.
- Three scalar select lines pick one of eight equal-width data inputs.
- Used as a generic leaf selector in datapaths.
- Registered output gives a timing-clean version for downstream synchronous logic.

Parameters:
- WIDTH, 1, bit width of each data input x1..x8 and of outputs y and y_q.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- x1  input  WIDTH  data input 1, selected when {s1,s2,s3}=3'b000.
- x2  input  WIDTH  data input 2, selected at 3'b001.
- x3  input  WIDTH  data input 3, selected at 3'b010.
- x4  input  WIDTH  data input 4, selected at 3'b011.
- x5  input  WIDTH  data input 5, selected at 3'b100.
- x6  input  WIDTH  data input 6, selected at 3'b101.
- x7  input  WIDTH  data input 7, selected at 3'b110.
- x8  input  WIDTH  data input 8, selected at 3'b111.
- s1  input  1  select MSB.
- s2  input  1  select middle bit.
- s3  input  1  select LSB.
- y  output  WIDTH  combinational selected data.
- y_q  output  WIDTH  registered selected data.
- sel_q  output  3  registered select value {s1,s2,s3}.

Port order of the first twelve ports is fixed: x1..x8, s1, s2, s3, y (positional instantiation is used in the codebase). clk, rst, y_q and sel_q follow in that order.

Behaviour:
- Select index sel = {s1,s2,s3}; s1 is MSB, s3 is LSB.
- y = x(sel+1): 0 -> x1, 1 -> x2, … 7 -> x8.
- y is purely combinational, zero latency, with no dependence on clk or rst.
- y tracks input or select changes within the same delta/time step.
- On each rising clk edge with rst=1: y_q <= 0 and sel_q <= 3'b000.
- On each rising clk edge with rst=0: y_q <= y and sel_q <= sel.
- Latency for y_q and sel_q is 1 cycle.
- rst asserted mid-operation clears y_q and sel_q at the next edge only. y is unaffected and keeps following inputs during reset.
- X or Z on any select bit: y is X (no priority default). y_q captures X when rst=0.
- All eight codes are legal; there is no invalid select code.
- No internal state beyond y_q, sel_q (and y_par when the optional feature is compiled in).

Optional Feature:
- Macro: MUX_8X1_PARITY_EN.
- When defined: adds output port y_par (1 bit), after sel_q.
  - y_par is registered even parity of the selected data: y_par <= ^y on each edge.
  - Reset value of y_par is 0.
  - y_par updates in the same cycle as y_q, so it always matches y_q.
- When not defined: y_par port and its register are absent. All other behaviour is identical.

Decomposition:
- Package mux_8x1_pkg holds:
  - SEL_W = 3.
  - Select code constants SEL_X1 = 3'd0 … SEL_X8 = 3'd7.
- One natural sub-module, mux_8x1_core: purely combinational WIDTH-parameterized 8:1 case-select producing y.
- Top level instantiates mux_8x1_core and adds the y_q/sel_q registers (and y_par when enabled).

Test Plan:
1. WIDTH=1; x1..x8 = 0,1,0,1,1,0,1,0; step sel 000→111 every 10 ns with no clock. Required y sequence: 0,1,0,1,1,0,1,0.
2. Same data, clock running, rst=0; hold sel=3'b100 for one edge. Required: y_q=1 and sel_q=3'b100 one cycle after the change; y=1 immediately.
3. Assert rst for one edge while sel=3'b011 and x4=1. Required: y_q=0 and sel_q=000 after that edge, y=1 throughout; after rst drops, y_q=1 at the next edge.
4. Hold sel=3'b010 and toggle x3 0→1→0 between edges. Required: y follows x3 instantly; y_q reflects only the value sampled at each edge.
5. WIDTH=8; x1..x8 = 8'h11,22,33,44,55,66,77,88; sel=3'b111. Required: y=8'h88. With MUX_8X1_PARITY_EN defined, after one edge y_q=8'h88 and y_par=0; with sel=3'b000, y_par=0 (8'h11 has even parity).
6. Random sel/data for 1000 cycles against a reference model. Required: y matches every cycle; y_q and sel_q match the previous cycle's y and sel.
